cap_rank_sequencer: RTL

- Consumes capacitor voltage samples and turns them into sorted ranks, then into submodule insertion gating for one MMC arm.
- Loads N IEEE-754 single-precision voltages and resolves all N(N-1)/2 pairwise comparisons sequentially, one pair per cycle.
- Each pair sets both C_ij and C_ji, and the C bits accumulate into per-cell ranks.
- Selects the n_on cells to insert based on arm current direction. Sits between the cell-voltage acquisition path and the gate-drive modulator.

---
 rtl/cap_rank_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cap_rank_sequencer.sv
// Capacitor-voltage rank sorter for one MMC arm.
// Loads N float32 cell voltages, resolves every pair sequentially (one per
// cycle) into per-cell ranks (0 = largest magnitude), then turns the ranks
// into an insertion mask according to arm current direction.
module cap_rank_sequencer #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 v_valid,
  output logic                 v_ready,
  input  logic [W-1:0]         v_data,
  input  logic [IDX_W:0]       n_on,
  input  logic                 arm_dir,
  output logic [N-1:0]         gate_mask,
  output logic [N*IDX_W-1:0]   rank_flat,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPARE, MASK} state_t;

  localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_I    = IDX_W'(N - 2);
  localparam logic [IDX_W:0]   N_W       = (IDX_W + 1)'(N);

  state_t                       state;
  // Only magnitudes are kept; the sign never takes part in the ordering.
  logic [N-1:0][W-2:0]          v_mag;
  logic [N-1:0][IDX_W-1:0]      rank_acc;
  logic [IDX_W-1:0]             load_cnt;
  logic [IDX_W-1:0]             pi, pj;
  logic [IDX_W:0]               n_on_q;
  logic                         dir_q;
  logic                         accept;
  logic                         c_ij;
  logic [IDX_W:0]               n_eff;
  logic [IDX_W:0]               hi_thr;
  logic [N-1:0]                 mask_nxt;
  logic                         unused_sign;

  assign unused_sign = v_data[W-1];
  assign v_ready     = (state == IDLE) || (state == LOAD);
  assign busy        = (state == COMPARE) || (state == MASK);
  assign accept      = v_valid && v_ready;

  // Exponent-then-mantissa unsigned compare equals one raw magnitude compare.
  // Ties give c_ij=0, so the lower index is treated as the larger cell.
  assign c_ij = v_mag[pi] < v_mag[pj];

  // Insertion mask from final ranks; n_on beyond N saturates to all cells.
  always_comb begin
    n_eff    = (n_on_q > N_W) ? N_W : n_on_q;
    hi_thr   = N_W - n_eff;
    mask_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (dir_q) mask_nxt[k] = ({1'b0, rank_acc[k]} >= hi_thr);
      else       mask_nxt[k] = ({1'b0, rank_acc[k]} <  n_eff);
    end
  end

  // Sequencer FSM: load, pairwise compare/accumulate, then publish results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      v_mag     <= '0;
      rank_acc  <= '0;
      load_cnt  <= '0;
      pi        <= '0;
      pj        <= '0;
      n_on_q    <= '0;
      dir_q     <= 1'b0;
      gate_mask <= '0;
      rank_flat <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            v_mag[0] <= v_data[W-2:0];
            load_cnt <= IDX_W'(1);
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            v_mag[load_cnt] <= v_data[W-2:0];
            if (load_cnt == LAST_CELL) begin
              state    <= COMPARE;
              n_on_q   <= n_on;
              dir_q    <= arm_dir;
              rank_acc <= '0;
              pi       <= '0;
              pj       <= IDX_W'(1);
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + IDX_W'(1);
            end
          end
        end
        COMPARE: begin
          for (int k = 0; k < N; k++) begin
            if (pi == IDX_W'(k))
              rank_acc[k] <= rank_acc[k] + IDX_W'(c_ij);
            else if (pj == IDX_W'(k))
              rank_acc[k] <= rank_acc[k] + IDX_W'(!c_ij);
          end
          if (pj == LAST_CELL) begin
            if (pi == LAST_I) begin
              state <= MASK;
            end else begin
              pi <= pi + IDX_W'(1);
              pj <= pi + IDX_W'(2);
            end
          end else begin
            pj <= pj + IDX_W'(1);
          end
        end
        MASK: begin
          gate_mask <= mask_nxt;
          rank_flat <= rank_acc;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
